sum_accumulator: RTL and testbench
==================================

# sum_accumulator

Downstream consumer of the 4-bit mux-select adder output. Accepts a stream of `sum` values over a valid/ready handshake and accumulates `FRAME_LEN` of them into a wider total. It presents the frame total on an output valid/ready handshake and stalls input until the total is taken. It is the first sequential stage after the combinational select/add block.

## Interface
- `DATA_W`, 4: width of incoming sum samples.
- `ACC_W`, 8: width of accumulator and `out_total`.
- `FRAME_LEN`, 4: samples per frame; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_sum`  in  DATA_W  sample from the select/add stage.
- `in_valid`  in  1  `in_sum` is valid.
- `in_ready`  out  1  block accepts a sample this cycle.
- `clear`  in  1  synchronous frame abort.
- `out_total`  out  ACC_W  frame total, held while `out_valid`.
- `out_count`  out  8  samples accepted in the current frame.
- `out_valid`  out  1  `out_total` is valid.
- `out_ready`  in  1  consumer takes `out_total`.
- `overflow`  out  1  sticky: the frame total exceeded the ACC_W range.

## Operation
- FSM states: FILL and DONE.
- Reset state is FILL. Reset values: acc=0, cnt=0, `out_total`=0, `out_count`=0, `out_valid`=0, `overflow`=0.
- `in_ready` = (state==FILL) && !clear && !rst. It depends on state only, never on `in_valid`.
- Accept = `in_valid` && `in_ready`.
- On accept in FILL: acc ← acc + zero-extended `in_sum`; cnt ← cnt+1.
- On the accept that brings cnt to FRAME_LEN:
  - `out_total` ← acc + `in_sum`.
  - Go to DONE; `out_valid` ← 1.
  - acc ← 0; cnt ← 0.
- In DONE: `in_ready`=0. `out_total` and `overflow` hold until `out_valid` && `out_ready`.
- On that handshake: `out_valid` ← 0, `overflow` ← 0, next state FILL.
- `clear` has top priority over accept and handshake. On `clear`: acc=0, cnt=0, state=FILL, `out_valid`=0, `overflow`=0. `out_total` keeps its last value.
- `out_count` mirrors cnt. In DONE it reads 0.
- Arithmetic is unsigned. The addition is performed at ACC_W+1 bits; the carry-out bit marks overflow.
- `in_valid` dropping mid-frame simply pauses accumulation; there is no timeout.
- Reset asserted mid-frame discards the partial frame immediately, asynchronously.

## Timing
- Sample accepted at edge N is reflected in acc/`out_count` after edge N.
- `out_valid` rises one cycle after the final sample's accept edge.
- Minimum frame period: FRAME_LEN accept cycles, plus 1 DONE cycle, plus out_ready wait cycles.
- `out_valid` falls on the edge following the handshake. `in_ready` rises in the same cycle.
- When `out_ready` is held high, back-to-back frames lose exactly one input cycle per frame.
- FRAME_LEN=1: every accept goes straight to DONE.

## Configuration
- Macro: `SUM_ACC_SATURATE_EN`.
- Defined:
  - On carry-out, acc clamps to all-ones and stays there for the rest of the frame.
  - `overflow` sets and is sticky until the frame handshake, `clear`, or `rst`.
- Undefined:
  - acc wraps modulo 2^ACC_W.
  - `overflow` is tied to 0.

## Structure
- Shared package `sum_acc_pkg` holds:
  - the state enum (FILL, DONE);
  - default widths `SUM_DATA_W`=4 and `SUM_ACC_W`=8;
  - `SUM_CNT_W`=8.
- One natural sub-module: `sum_acc_frame_ctr`. It is the frame sample counter with increment, clear, and a terminal-count flag at FRAME_LEN-1. The FSM and accumulator stay in the top.

## Test plan
- Reset, FRAME_LEN=4, inputs 3,5,7,9 on consecutive cycles with `out_ready`=1 → `out_total`=24, `out_valid` for 1 cycle, `in_ready` low that cycle, `overflow`=0.
- Same frame with `out_ready`=0 for 5 cycles → `out_total`=24 held; `in_ready`=0 throughout; released on the handshake edge.
- `in_valid` gaps: samples 2,_,_,4,_,6,1 → total 13 after the 4th accept; `out_count` steps 1,1,1,2,2,3.
- `clear` asserted after 2 samples (1,1), then 4,4,4,4 → `out_total`=16; no `out_valid` for the aborted frame.
- FRAME_LEN=20, ACC_W=8, all inputs 15:
  - with `SUM_ACC_SATURATE_EN` → `out_total`=255, `overflow`=1;
  - without → `out_total`=44, `overflow`=0.
- `rst` pulsed mid-frame asynchronously after 3 samples → all outputs 0 immediately; the next 4 samples of 1 give `out_total`=4.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the sum accumulator.
// The saturating build is selected by defining SUM_ACC_SATURATE_EN.
package sum_acc_pkg;

  localparam int SUM_DATA_W = 4;
  localparam int SUM_ACC_W  = 8;
  localparam int SUM_CNT_W  = 8;

  typedef enum logic {
    FILL = 1'b0,
    DONE = 1'b1
  } sum_state_e;

endpackage

// File: rtl/sum_acc_if.sv
// Input sample stream and output frame total of the sum accumulator.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid never waits on ready, in_ready never looks at in_valid, and data holds while valid.
interface sum_acc_if
  import sum_acc_pkg::*;
#(
  parameter int DATA_W = SUM_DATA_W,
  parameter int ACC_W  = SUM_ACC_W
);

  logic [DATA_W-1:0]    in_sum;
  logic                 in_valid;
  logic                 in_ready;
  logic                 clear;
  logic [ACC_W-1:0]     out_total;
  logic [SUM_CNT_W-1:0] out_count;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;

  modport master (
    output in_sum, in_valid, clear, out_ready,
    input  in_ready, out_total, out_count, out_valid, overflow
  );

  modport slave (
    input  in_sum, in_valid, clear, out_ready,
    output in_ready, out_total, out_count, out_valid, overflow
  );

endinterface

// File: rtl/sum_acc_frame_ctr.sv
// Frame sample counter: counts accepted samples and wraps to zero on the
// sample that completes the frame; tc_o flags the last slot of the frame.
module sum_acc_frame_ctr
  import sum_acc_pkg::*;
#(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = SUM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o  = (cnt_q == TC_VAL);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates FRAME_LEN input samples into one frame total and holds it until taken.
// SUM_ACC_SATURATE_EN: clamp the total at all-ones and raise a sticky overflow; otherwise wrap.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int DATA_W    = SUM_DATA_W,
  parameter int ACC_W     = SUM_ACC_W,
  parameter int FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  sum_acc_if.slave   bus,
  output sum_state_e dbg_state_o
);

  sum_state_e           state_q;
  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     acc_d;
  logic [ACC_W-1:0]     total_q;
  logic                 valid_q;
  logic                 ovf_q;
  logic                 ovf_set;
  logic                 accept;
  logic                 last;
  logic [DATA_W-1:0]    sample;
  logic [SUM_CNT_W-1:0] cnt;

  assign sample      = bus.in_sum;
  assign bus.in_ready = (state_q == FILL) && !bus.clear && !rst;
  assign accept      = bus.in_valid && bus.in_ready;

`ifdef SUM_ACC_SATURATE_EN
  localparam int SUM_W = ACC_W + 1;
  logic [ACC_W:0] sum_w;

  // Once clamped, further adds carry again, so acc stays at all-ones for the frame.
  assign sum_w   = {1'b0, acc_q} + SUM_W'(sample);
  assign ovf_set = sum_w[ACC_W];
  assign acc_d   = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
`else
  assign ovf_set = 1'b0;
  assign acc_d   = acc_q + ACC_W'(sample);
`endif

  sum_acc_frame_ctr #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (SUM_CNT_W)
  ) u_frame_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.clear),
    .inc_i (accept),
    .cnt_o (cnt),
    .tc_o  (last)
  );

  // clear outranks both accept and the output handshake; out_total survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      acc_q   <= '0;
      total_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.clear) begin
      state_q <= FILL;
      acc_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            if (ovf_set) begin
              ovf_q <= 1'b1;
            end
            if (last) begin
              total_q <= acc_d;
              acc_q   <= '0;
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              acc_q <= acc_d;
            end
          end
        end
        DONE: begin
          if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.out_total = total_q;
  assign bus.out_count = cnt;
  assign bus.out_valid = valid_q;
  assign bus.overflow  = ovf_q;
  assign dbg_state_o   = state_q;

  a_no_ready_in_done: assert property (
    @(posedge clk) disable iff (rst) valid_q |-> !bus.in_ready
  );

  a_total_held: assert property (
    @(posedge clk) disable iff (rst)
      (valid_q && !bus.out_ready && !bus.clear) |=> (valid_q && $stable(total_q))
  );

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three instances (FRAME_LEN 4, 20, 1) share one stimulus stream;
// a frame-level model predicts each total and a monitor checks every cycle.
`timescale 1ns/1ps
module tb_sum_accumulator;
  import sum_acc_pkg::*;

  localparam int N_DUT = 3;

`ifdef SUM_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  function automatic int frame_len(input int d);
    case (d)
      0:       return 4;
      1:       return 20;
      default: return 1;
    endcase
  endfunction

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] in_sum    = '0;
  logic       in_valid  = 1'b0;
  logic       clear     = 1'b0;
  logic       out_ready = 1'b0;

  sum_acc_if #(.DATA_W(4), .ACC_W(8)) bus0 ();
  sum_acc_if #(.DATA_W(4), .ACC_W(8)) bus1 ();
  sum_acc_if #(.DATA_W(4), .ACC_W(8)) bus2 ();

  assign bus0.in_sum = in_sum;  assign bus0.in_valid = in_valid;
  assign bus0.clear  = clear;   assign bus0.out_ready = out_ready;
  assign bus1.in_sum = in_sum;  assign bus1.in_valid = in_valid;
  assign bus1.clear  = clear;   assign bus1.out_ready = out_ready;
  assign bus2.in_sum = in_sum;  assign bus2.in_valid = in_valid;
  assign bus2.clear  = clear;   assign bus2.out_ready = out_ready;

  sum_state_e st_w [N_DUT];

  sum_accumulator #(.DATA_W(4), .ACC_W(8), .FRAME_LEN(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_state_o(st_w[0]));
  sum_accumulator #(.DATA_W(4), .ACC_W(8), .FRAME_LEN(20)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state_o(st_w[1]));
  sum_accumulator #(.DATA_W(4), .ACC_W(8), .FRAME_LEN(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .dbg_state_o(st_w[2]));

  logic       rdy_w [N_DUT];
  logic       val_w [N_DUT];
  logic       ovf_w [N_DUT];
  logic [7:0] tot_w [N_DUT];
  logic [7:0] cnt_w [N_DUT];

  assign rdy_w[0] = bus0.in_ready; assign val_w[0] = bus0.out_valid; assign ovf_w[0] = bus0.overflow;
  assign tot_w[0] = bus0.out_total; assign cnt_w[0] = bus0.out_count;
  assign rdy_w[1] = bus1.in_ready; assign val_w[1] = bus1.out_valid; assign ovf_w[1] = bus1.overflow;
  assign tot_w[1] = bus1.out_total; assign cnt_w[1] = bus1.out_count;
  assign rdy_w[2] = bus2.in_ready; assign val_w[2] = bus2.out_valid; assign ovf_w[2] = bus2.overflow;
  assign tot_w[2] = bus2.out_total; assign cnt_w[2] = bus2.out_count;

  // reference model state (value after the most recent edge)
  int         fsum     [N_DUT] = '{0, 0, 0};
  int         fn       [N_DUT] = '{0, 0, 0};
  bit         done     [N_DUT] = '{0, 0, 0};
  bit         eovf     [N_DUT] = '{0, 0, 0};
  logic [7:0] last_tot [N_DUT] = '{8'd0, 8'd0, 8'd0};
  logic [8:0] exp_q    [N_DUT][$];

  int n_chk  = 0;
  int n_fail = 0;
  bit final_req  = 1'b0;
  bit final_done = 1'b0;

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0d, expected %0d at %0t", d, name, act, exp, $time);
    end
  endtask

  // model: decides at the falling edge what the coming rising edge does
  always @(negedge clk) begin
    int t;
    for (int d = 0; d < N_DUT; d++) begin
      if (rst || clear) begin
        if (done[d]) void'(exp_q[d].pop_back());
        fsum[d] = 0;
        fn[d]   = 0;
        done[d] = 1'b0;
        eovf[d] = 1'b0;
        if (rst) last_tot[d] = 8'd0;
      end else if (!done[d] && in_valid) begin
        fsum[d] += int'(in_sum);
        fn[d]++;
        eovf[d] = SAT && (fsum[d] > 255);
        if (fn[d] == frame_len(d)) begin
          if (SAT) t = (fsum[d] > 255) ? 255 : fsum[d];
          else     t = fsum[d] % 256;
          last_tot[d] = 8'(t);
          exp_q[d].push_back({eovf[d], 8'(t)});
          done[d] = 1'b1;
          fn[d]   = 0;
          fsum[d] = 0;
        end
      end else if (done[d] && out_ready) begin
        done[d] = 1'b0;
        eovf[d] = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [8:0] e;
    #3;
    for (int d = 0; d < N_DUT; d++) begin
      if (rst) begin
        chk(d, "rst_ready", 32'(rdy_w[d]), 32'd0);
        chk(d, "rst_valid", 32'(val_w[d]), 32'd0);
        chk(d, "rst_count", 32'(cnt_w[d]), 32'd0);
        chk(d, "rst_total", 32'(tot_w[d]), 32'd0);
        chk(d, "rst_overflow", 32'(ovf_w[d]), 32'd0);
      end else begin
        chk(d, "in_ready", 32'(rdy_w[d]), 32'(!done[d] && !clear));
        chk(d, "out_valid", 32'(val_w[d]), 32'(done[d]));
        chk(d, "out_count", 32'(cnt_w[d]), 32'(fn[d]));
        chk(d, "out_total", 32'(tot_w[d]), 32'(last_tot[d]));
        chk(d, "overflow", 32'(ovf_w[d]), 32'(eovf[d]));
        chk(d, "state", 32'(st_w[d]), 32'(done[d] ? DONE : FILL));
        if (val_w[d] && out_ready && !clear) begin
          if (exp_q[d].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut%0d frame: got out_valid with total %0d, expected no frame", d, tot_w[d]);
          end else begin
            e = exp_q[d].pop_front();
            chk(d, "frame_total", 32'(tot_w[d]), 32'(e[7:0]));
            chk(d, "frame_overflow", 32'(ovf_w[d]), 32'(e[8]));
          end
        end
      end
    end
    if (final_req && !final_done) begin
      for (int d = 0; d < N_DUT; d++) chk(d, "frames_left", 32'(exp_q[d].size()), 32'd0);
      final_done = 1'b1;
    end
  end

  // driver
  task automatic step(input logic [3:0] s, input logic v, input logic c, input logic r);
    @(posedge clk);
    #1;
    in_sum    = s;
    in_valid  = v;
    clear     = c;
    out_ready = r;
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) step(4'd0, 1'b0, 1'b0, r);
  endtask

  logic [3:0] gap_val [7] = '{4'd2, 4'd0, 4'd0, 4'd4, 4'd0, 4'd6, 4'd1};
  logic       gap_vld [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // basic frame 3,5,7,9 with consumer ready
    step(4'd3, 1'b1, 1'b0, 1'b1); step(4'd5, 1'b1, 1'b0, 1'b1);
    step(4'd7, 1'b1, 1'b0, 1'b1); step(4'd9, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // same frame, consumer stalls for 5 cycles while input keeps offering
    step(4'd0, 1'b0, 1'b1, 1'b0);
    step(4'd3, 1'b1, 1'b0, 1'b0); step(4'd5, 1'b1, 1'b0, 1'b0);
    step(4'd7, 1'b1, 1'b0, 1'b0); step(4'd9, 1'b1, 1'b0, 1'b0);
    repeat (5) step(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // valid gaps pause accumulation
    step(4'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(gap_val[i], gap_vld[i], 1'b0, 1'b1);
    idle(2, 1'b1);

    // abort after two samples, then a full frame of 4s
    step(4'd0, 1'b0, 1'b1, 1'b1);
    step(4'd1, 1'b1, 1'b0, 1'b1); step(4'd1, 1'b1, 1'b0, 1'b1);
    step(4'd0, 1'b0, 1'b1, 1'b1);
    repeat (4) step(4'd4, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // long frame of 15s overruns the 8-bit total on the FRAME_LEN=20 instance
    step(4'd0, 1'b0, 1'b1, 1'b1);
    repeat (25) step(4'd15, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // asynchronous reset mid-frame, then a frame of 1s
    step(4'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) step(4'd1, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    repeat (4) step(4'd1, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // randomized traffic with backpressure and occasional aborts
    repeat (600) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 9) < 6));
    end

    // occasional async reset in the middle of random traffic
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) begin
      step(4'($urandom_range(8, 15)), 1'($urandom_range(0, 9) < 8),
           1'b0, 1'($urandom_range(0, 9) < 7));
    end

    idle(30, 1'b1);
    final_req = 1'b1;
    repeat (3) @(posedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
